// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around one full_adder.
// The operands are added LSB first, one bit per clk edge. The sum bits shift
// into the result register from the MSB side.
// Optional feature macro: SERIAL_ADD_SUB_EN. It adds the input port 'sub'.
// When sub=1, the block computes op_a - op_b: B is inverted and the carry-in
// is forced to 1.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; result/cout hold the last answer
// RUN    | one sum bit per edge; the counter tracks the bits done
// DONE   | result/cout valid, done pulses for this single cycle

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  // single-bit sum and carry
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  // The counter can reach WIDTH without wrapping, even at WIDTH=2.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic fa_b;
  logic fa_sum;
  logic fa_carry;
  logic carry_in;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1. The inversion is applied on the way into the
  // adder, so the operand register keeps the raw B value.
  assign fa_b     = b_q[0] ^ sub_q;
  assign carry_in = sub;
`else
  assign fa_b     = b_q[0];
  assign carry_in = 1'b0;
`endif

  full_adder u_fa (
    .a     (a_q[0]),
    .b     (fa_b),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Sequencer: operand capture, bit-serial datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= carry_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          res_q   <= {fa_sum, res_q[WIDTH-1:1]};
          carry_q <= fa_carry;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // After the last RUN edge, the carry flop holds the final carry-out. It
  // keeps that value until the next accepted start reloads it.
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign cout   = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub    (sub),
`endif
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation, waits for done, then checks the latency, the
  // number of busy cycles, the result, the single-cycle done pulse and
  // the hold of the result after done.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] exp_res, input logic exp_cout);
    int k;
    int nbusy;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    step();
    start = 1'b0;
    k     = 0;
    nbusy = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) nbusy++;
      step();
      k++;
    end
    check({tag, " latency"}, k, 8);
    check({tag, " busy_cycles"}, nbusy, 8);
    check({tag, " busy_at_done"}, {31'd0, busy}, 0);
    check({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
    check({tag, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
    step();
    check({tag, " done_pulse_end"}, {31'd0, done}, 0);
    check({tag, " result_hold"}, {24'd0, result}, {24'd0, exp_res});
    check({tag, " cout_hold"}, {31'd0, cout}, {31'd0, exp_cout});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int pulses;
    int first_at;
    int last_at;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset result", {24'd0, result}, 0);
    check("reset cout", {31'd0, cout}, 0);
    rst_n = 1'b1;
    step();

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run_op("ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

    // Start is pulsed mid-RUN and the operands change after capture.
    op_a  = 8'h5A;
    op_b  = 8'h33;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    op_a  = 8'h12;
    op_b  = 8'h34;
    start = 1'b1;
    step();
    start = 1'b0;
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    k = 3;
    while (done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("ignore latency", k, 8);
    check("ignore result", {24'd0, result}, 32'h8D);
    check("ignore cout", {31'd0, cout}, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("ignore extra_done", pulses, 0);
    check("ignore idle_busy", {31'd0, busy}, 0);

    // Reset is asserted during the 4th RUN cycle.
    op_a  = 8'hAA;
    op_b  = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("abort busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    check("abort result", {24'd0, result}, 0);
    check("abort cout", {31'd0, cout}, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("abort no_done", pulses, 0);
    run_op("01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Start is held high: a new operation begins every 10 cycles.
    op_a     = 8'h10;
    op_b     = 8'h10;
    start    = 1'b1;
    pulses   = 0;
    first_at = -1;
    last_at  = -1;
    for (int c = 0; c < 35; c++) begin
      step();
      if (done === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = c;
        else check("hold period", c - last_at, 10);
        last_at = c;
        check("hold result", {24'd0, result}, 32'h20);
        check("hold cout", {31'd0, cout}, 0);
      end
    end
    start = 1'b0;
    check("hold pulses", pulses, 3);
    check("hold first_done", first_at, 8);
    step();
    step();
    step();

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub 10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op("sub 01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    run_op("sub0 add", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  operand A; captured on accepted start.
REQ-006 op_b  input  WIDTH  operand B; captured on accepted start.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  single-cycle pulse, high while in DONE.
REQ-009 result  output  WIDTH  sum bits; valid while done is high and held until the next accepted start.
REQ-010 cout  output  1  final carry-out; same validity as result.

Function
REQ-011 The block SHALL instantiate exactly one full_adder (ports a, b, c, sum, carry) and compute the WIDTH-bit sum bit-serially, LSB first, one bit per clock.
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at edge E0: capture op_a/op_b into shift registers, clear bit counter, load carry flop with carry-in (0 for add), go to RUN.
REQ-014 RUN: each edge E1..EWIDTH SHALL feed the current LSBs of A, B and the carry flop to the full_adder, shift sum into result from the MSB side, store carry into the carry flop, increment the counter.
REQ-015 At edge EWIDTH the FSM SHALL go to DONE; done=1 for exactly the cycle after EWIDTH; at edge EWIDTH+1 return to IDLE.
REQ-016 Latency from accepted start to done SHALL be WIDTH+1 edges; back-to-back start is accepted no earlier than the IDLE cycle after DONE.
REQ-017 start SHALL be ignored in RUN and DONE; operands changing after capture SHALL not affect the result.
REQ-018 result SHALL equal (op_a + op_b) mod 2^WIDTH and cout SHALL equal bit WIDTH of the full sum.
REQ-019 result/cout SHALL hold their last values in IDLE; they are undefined-to-the-user (but deterministic) during RUN.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, cout=0, counter=0, carry flop=0, operand registers=0.
REQ-021 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.

Configuration
REQ-022 Macro SERIAL_ADD_SUB_EN: when defined, an extra input port sub (1 bit) SHALL exist, sampled with start.
REQ-023 With SERIAL_ADD_SUB_EN and sub=1: B bits SHALL be inverted before the full_adder and carry-in set to 1, giving result = (op_a - op_b) mod 2^WIDTH, cout = 1 meaning no borrow; sub=0 behaves as plain add.
REQ-024 Without SERIAL_ADD_SUB_EN: no sub port, carry-in always 0, add only.

Verification (WIDTH=8)
REQ-025 Reset, then start with 0x00+0x00 -> done exactly 9 edges after start, result=0x00, cout=0, busy high for 8 cycles.
REQ-026 0xFF+0x01 -> result=0x00, cout=1; 0x5A+0x33 -> result=0x8D, cout=0.
REQ-027 Pulse start again during RUN with different operands -> ignored; original result delivered, single done pulse.
REQ-028 Assert rst_n low at 4th RUN cycle of 0xAA+0x55 -> outputs zero immediately, no done; subsequent 0x01+0x02 -> result=0x03, cout=0.
REQ-029 Hold start high continuously with 0x10+0x10 -> result=0x20 every WIDTH+2 cycles, done pulses one cycle each.
REQ-030 SERIAL_ADD_SUB_EN defined: sub=1, 0x10-0x01 -> result=0x0F, cout=1; 0x01-0x02 -> result=0xFF, cout=0.
